coin_input_conditioner: RTL
===========================

COIN_INPUT_CONDITIONER -- requirements
Module: coin_input_conditioner

Interface
REQ-001 Parameter DB_W, default 16: width of each debounce counter.
REQ-002 Parameter DB_LIMIT, default 50000: consecutive mismatching cycles needed to accept a level change; legal range 1..2^DB_W-1.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset: rst, synchronous, active-low; clock clk.
REQ-005 switch  input  4  raw coin inputs, active-high, asynchronous; bit0=1, bit1=5, bit2=10, bit3=20 units.
REQ-006 L_button, R_button, C_button  input  1 each  raw push buttons, active-high, asynchronous.
REQ-007 coin_inhibit  input  1  synchronous; high = new coin edges discarded.
REQ-008 coin_valid  output  1  registered one-cycle strobe: one coin accepted.
REQ-009 coin_value  output  5  registered; 1/5/10/20 while coin_valid=1, else 0.
REQ-010 l_pulse, r_pulse, c_pulse  output  1 each  registered one-cycle button press strobes.
REQ-011 coin_overrun  output  1  registered one-cycle strobe: coin edge lost to a full pending slot.

Function
REQ-012 Each of the 7 raw inputs SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-013 Per input: stable level reg plus DB_W-bit counter; sync2==stable -> counter cleared to 0.
REQ-014 sync2!=stable and counter<DB_LIMIT-1 -> counter+1; sync2!=stable and counter==DB_LIMIT-1 -> stable<=sync2, counter<=0.
REQ-015 A single-cycle glitch or any bounce shorter than DB_LIMIT cycles SHALL not change stable.
REQ-016 Event = edge at which stable goes 0->1; falling transitions debounce identically but generate no event.
REQ-017 Latency: raw input first sampled high at edge 0 and held -> stable and button pulse high after edge DB_LIMIT+2.
REQ-018 Button event -> matching *_pulse high for exactly one cycle, registered at the event edge.
REQ-019 L and R events on the same edge SHALL both be suppressed (no l_pulse, no r_pulse); C_button independent.
REQ-020 Coin event with coin_inhibit=0 -> pending[i] set at the event edge; with coin_inhibit=1 -> discarded, no pending, no overrun.
REQ-021 Issue stage: each cycle, if any pending bit set, lowest index i SHALL be issued: coin_valid=1, coin_value=value(i) on next edge, pending[i] cleared.
REQ-022 Single isolated coin: coin_valid high after edge DB_LIMIT+3 (one cycle after button-equivalent timing).
REQ-023 Simultaneous coin events SHALL be serialized one per cycle in ascending index order; no coin lost, none duplicated.
REQ-024 Coin event on index i while pending[i]=1 and pending[i] not being cleared that edge -> event dropped, coin_overrun pulses one cycle.
REQ-025 Same-edge issue of i and new event on i -> pending[i] stays set (new event retained), no overrun.
REQ-026 coin_inhibit does not affect already-pending coins; they issue normally.
REQ-027 coin_valid never high on two consecutive cycles unless two or more coins were pending.
REQ-028 Counters never wrap; value bounded by DB_LIMIT-1.

Reset
REQ-029 rst=0 at a clock edge -> all sync flops, stable regs, counters, pending bits cleared to 0.
REQ-030 Output reset values: coin_valid=0, coin_value=0, l_pulse=r_pulse=c_pulse=0, coin_overrun=0.
REQ-031 Reset mid-debounce or with coins pending SHALL abandon them; no strobe issued for pre-reset activity.
REQ-032 Input held high across reset release SHALL be treated as a new press: event after DB_LIMIT+2 edges.

Verification (DB_LIMIT=4)
REQ-033 switch[1] 0->1 held -> single coin_valid with coin_value=5 after edge 7; no further strobes while held.
REQ-034 C_button toggling every 2 cycles for 20 cycles then held high -> exactly one c_pulse, after edge 6 from start of hold.
REQ-035 switch[3:0] 0000->1111 same cycle -> coin_valid on 4 consecutive cycles, values 1,5,10,20.
REQ-036 L_button and R_button rise same cycle -> no l_pulse, no r_pulse; C_button same cycle -> c_pulse still issued.
REQ-037 coin_inhibit=1 during switch[2] event -> no coin_valid, no overrun; inhibit=0 and a new switch[2] press -> value 10 issued.
REQ-038 rst=0 for one cycle at edge 5 of a switch[0] debounce -> no coin_valid until edge 6 after rst returns high.

Source files
------------

// File: rtl/coin_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : coin_input_conditioner
// Purpose  : Synchronises, debounces and edge-detects coin and button inputs;
//            serialises accepted coins into one-cycle value strobes.
// Revision : 1.0
// ============================================================================
module coin_input_conditioner #(
    parameter int DB_W     = 16,
    parameter int DB_LIMIT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] switch,
    input  logic       L_button,
    input  logic       R_button,
    input  logic       C_button,
    input  logic       coin_inhibit,
    output logic       coin_valid,
    output logic [4:0] coin_value,
    output logic       l_pulse,
    output logic       r_pulse,
    output logic       c_pulse,
    output logic       coin_overrun
);

    localparam logic [DB_W-1:0] c_lim_m1 = DB_W'(DB_LIMIT - 1);

    // Bit order: [3:0] coins, [4] L, [5] R, [6] C
    logic [6:0] w_raw;
    logic [6:0] r_sync1;
    logic [6:0] r_sync2;
    logic [6:0] w_stable;
    logic [6:0] r_stable_q;
    logic [6:0] w_evt;
    logic [3:0] w_coin_evt;
    logic [3:0] r_pend;
    logic [3:0] w_issue;
    logic [3:0] w_pend_nxt;
    logic       w_ovr;
    logic [4:0] w_val;

    assign w_raw = {C_button, R_button, L_button, switch};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable_q <= '0;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_stable_q <= w_stable;
        end
    end

    for (genvar gi = 0; gi < 7; gi++) begin : g_db
        logic            r_lvl;
        logic [DB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_lvl <= 1'b0;
                r_cnt <= '0;
            end else if (r_sync2[gi] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == c_lim_m1) begin
                r_lvl <= r_sync2[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_stable[gi] = r_lvl;
    end

    assign w_evt      = w_stable & ~r_stable_q;
    assign w_coin_evt = w_evt[3:0] & {4{~coin_inhibit}};

    // Lowest pending index wins; a same-edge re-arrival on the issued slot is kept.
    always_comb begin
        w_issue = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_pend[i] && (w_issue == 4'b0000)) begin
                w_issue[i] = 1'b1;
            end
        end
        w_pend_nxt = (r_pend & ~w_issue) | w_coin_evt;
        w_ovr      = |(w_coin_evt & r_pend & ~w_issue);
        w_val      = 5'd0;
        if (w_issue[0]) w_val = 5'd1;
        if (w_issue[1]) w_val = 5'd5;
        if (w_issue[2]) w_val = 5'd10;
        if (w_issue[3]) w_val = 5'd20;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend       <= '0;
            coin_valid   <= 1'b0;
            coin_value   <= '0;
            l_pulse      <= 1'b0;
            r_pulse      <= 1'b0;
            c_pulse      <= 1'b0;
            coin_overrun <= 1'b0;
        end else begin
            r_pend       <= w_pend_nxt;
            coin_valid   <= |w_issue;
            coin_value   <= w_val;
            l_pulse      <= w_evt[4] & ~w_evt[5];
            r_pulse      <= w_evt[5] & ~w_evt[4];
            c_pulse      <= w_evt[6];
            coin_overrun <= w_ovr;
        end
    end

endmodule
`default_nettype wire
